// File: rtl/cnn_pkg.sv
`default_nettype none
// ==========================================================================
// cnn_pkg : shared word width, word type and saturation limits for the CNN datapath
// Revision 1.0
// ==========================================================================
package cnn_pkg;

  localparam int CNN_XLEN = 16;

  typedef logic signed [CNN_XLEN-1:0] cnn_word_t;

  localparam cnn_word_t CNN_MAX = {1'b0, {(CNN_XLEN-1){1'b1}}};
  localparam cnn_word_t CNN_MIN = {1'b1, {(CNN_XLEN-1){1'b0}}};

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/cnn_adder_1bit_full_adder_1b.sv
`default_nettype none
// ==========================================================================
// full_adder_1b : single-bit combinational full adder (ripple-chain cell)
// Revision 1.0
// ==========================================================================
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule : full_adder_1b
`default_nettype wire

// File: rtl/cnn_adder_1bit.sv
`default_nettype none
// ==========================================================================
// cnn_adder_1bit : signed ripple-carry adder with saturation, 1-cycle registered result
// Revision 1.0
// ==========================================================================
module cnn_adder_1bit
  import cnn_pkg::*;
#(
  parameter int XLEN = CNN_XLEN
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic signed [XLEN-1:0] A,
  input  logic signed [XLEN-1:0] B,
  output logic                   out_valid,
  output logic signed [XLEN-1:0] OUT,
  output logic                   ovf
);

  localparam logic signed [XLEN-1:0] c_sat_max = {1'b0, {(XLEN-1){1'b1}}};
  localparam logic signed [XLEN-1:0] c_sat_min = {1'b1, {(XLEN-1){1'b0}}};

  logic [XLEN:0]            w_carry;
  logic [XLEN-1:0]          w_sum;
  logic                     w_ovf;
  logic signed [XLEN-1:0]   w_sat;

  logic                     r_valid;
  logic signed [XLEN-1:0]   r_out;
  logic                     r_ovf;

  assign w_carry[0] = 1'b0;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_ripple
    full_adder_1b u_fa (
      .a    (A[gi]),
      .b    (B[gi]),
      .cin  (w_carry[gi]),
      .s    (w_sum[gi]),
      .cout (w_carry[gi+1])
    );
  end

  // Carry into the MSB differing from carry out of it is exactly the case of
  // equal operand signs with a flipped result sign; the result value ignores cout.
  assign w_ovf = w_carry[XLEN-1] ^ w_carry[XLEN];

  always_comb begin
    w_sat = w_sum;
    if (w_ovf) begin
      w_sat = A[XLEN-1] ? c_sat_min : c_sat_max;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_sat;
        r_ovf <= w_ovf;
      end
    end
  end

  assign out_valid = r_valid;
  assign OUT       = r_out;
  assign ovf       = r_ovf;

endmodule : cnn_adder_1bit
`default_nettype wire

// File: tb/tb_cnn_adder_1bit.sv
`default_nettype none
// ==========================================================================
// tb_cnn_adder_1bit : directed and random checks of the saturating adder
// Revision 1.0
// ==========================================================================
module tb_cnn_adder_1bit;

  localparam int XLEN = 16;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic signed [XLEN-1:0] A;
  logic signed [XLEN-1:0] B;
  logic                   out_valid;
  logic signed [XLEN-1:0] OUT;
  logic                   ovf;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] exp_out;
  logic            exp_ovf;
  logic            exp_valid;

  cnn_adder_1bit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .OUT       (OUT),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer sum, clamped to the signed 16-bit range.
  task automatic model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic v);
    int sum;
    exp_valid = v;
    if (v) begin
      sum = int'($signed(a)) + int'($signed(b));
      if (sum > 32767) begin
        exp_out = 16'h7FFF; exp_ovf = 1'b1;
      end else if (sum < -32768) begin
        exp_out = 16'h8000; exp_ovf = 1'b1;
      end else begin
        exp_out = 16'(sum); exp_ovf = 1'b0;
      end
    end
  endtask

  task automatic check(input string tag);
    checks++;
    assert (out_valid === exp_valid) else begin
      errors++;
      $error("FAIL %s out_valid: got %b expected %b", tag, out_valid, exp_valid);
    end
    checks++;
    assert (OUT === exp_out) else begin
      errors++;
      $error("FAIL %s OUT: got %h expected %h", tag, OUT, exp_out);
    end
    checks++;
    assert (ovf === exp_ovf) else begin
      errors++;
      $error("FAIL %s ovf: got %b expected %b", tag, ovf, exp_ovf);
    end
  endtask

  task automatic step(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic v,
                      input string tag);
    @(negedge clk);
    A = a; B = b; in_valid = v;
    model(a, b, v);
    @(posedge clk);
    #1;
    check(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; A = 16'h1234; B = 16'h1234;
    exp_out = '0; exp_ovf = 1'b0; exp_valid = 1'b0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;

    step(16'h00AA, 16'h0092, 1'b1, "basic0");
    if (OUT !== 16'h013C) begin errors++; $error("FAIL basic0_const OUT: got %h expected 013c", OUT); end
    checks++;
    step(16'h0001, 16'h0011, 1'b1, "basic1");
    step(16'h5555, 16'h2222, 1'b0, "hold");
    checks++;
    assert (OUT === 16'h0012) else begin
      errors++;
      $error("FAIL hold_const OUT: got %h expected 0012", OUT);
    end
    step(16'hFFFD, 16'h00A0, 1'b1, "basic2");

    step(16'hF0FF, 16'hF0FF, 1'b1, "neg0");
    step(16'hF050, 16'hF034, 1'b1, "neg1");
    step(16'h80A8, 16'h0024, 1'b1, "neg2");

    step(16'h7FFF, 16'h0001, 1'b1, "satpos");
    step(16'h8000, 16'hFFFF, 1'b1, "satneg");
    step(16'h7FFF, 16'h8000, 1'b1, "mixed");
    step(16'h8000, 16'h8000, 1'b1, "satneg_min");
    step(16'h4000, 16'h4000, 1'b1, "satpos_half");

    for (int i = 0; i < 100; i++) begin
      step(16'($urandom), 16'($urandom), 1'b1, "stream");
    end

    // Reset arriving during traffic must clear the result.
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; A = 16'h7FFF; B = 16'h7FFF;
    exp_out = '0; exp_ovf = 1'b0; exp_valid = 1'b0;
    @(posedge clk);
    #1;
    check("reset_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cnn_adder_1bit
`default_nettype wire
